pll_tick_sequencer: RTL

Downstream consumer of the divided clock `clk_pll` produced by the 10 MHz divider. The block runs entirely in the `clk_10MHz` domain. It synchronises `clk_pll`, turns each rising edge into a one-cycle `tick`, and steps an 8-bit LED pattern engine on every tick. It also counts steps and flags a stalled divider when no edge arrives within a timeout.

---
 rtl/pll_seq_pkg.sv | 30 +++
 rtl/pll_edge_sync.sv | 30 +++
 rtl/pll_tick_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared constants and types for the PLL tick sequencer: mode encodings,
// LED reset pattern, default stall timeout and bounce direction.
package pll_seq_pkg;

  // Pattern mode encodings as seen on the mode input
  localparam logic [1:0] MODE_ROTATE = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_COUNT  = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  // Pattern shown after reset and loaded when a shift mode starts from a
  // value that is not one-hot
  localparam logic [7:0] LED_RESET = 8'h01;

  // Slightly longer than one 1 Hz period at 10 MHz, so a healthy divider
  // never trips the monitor
  localparam int unsigned STALL_LIMIT_DEFAULT = 12_000_000;

  // Direction of travel for the bounce pattern
  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  // True when exactly one bit of the pattern is set
  function automatic logic is_one_hot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/pll_edge_sync.sv
// Brings the asynchronous divided clock into the clk_10MHz domain and turns
// each rising edge into a single-cycle tick. SYNC_STAGES must be at least 2.
module pll_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_10MHz,
  input  logic rst,
  input  logic clk_pll,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;

  // Shift clk_pll through the synchroniser chain; hist_reg holds the previous
  // settled value so the edge detector sees only registered signals
  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], clk_pll};
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Rising edge of the settled signal; falling edges give nothing
  assign tick = sync_reg[SYNC_STAGES-1] & ~hist_reg;

endmodule

// File: rtl/pll_tick_sequencer.sv
// Steps an 8-bit LED pattern on every rising edge of the divided clock,
// counts the steps and flags a stalled divider after a long silence.
module pll_tick_sequencer
  import pll_seq_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
  input  logic        clk_10MHz,
  input  logic        rst,
  input  logic        clk_pll,
  input  logic        enable,
  input  logic [1:0]  mode,
  output logic        tick,
  output logic [7:0]  leds,
  output logic [15:0] step_count,
  output logic        stall
);

  // Pattern engine states, derived from mode and the stored bounce direction
  localparam logic [2:0] ST_ROTATE    = 3'd0;
  localparam logic [2:0] ST_BOUNCE_UP = 3'd1;
  localparam logic [2:0] ST_BOUNCE_DN = 3'd2;
  localparam logic [2:0] ST_COUNT     = 3'd3;
  localparam logic [2:0] ST_HOLD      = 3'd4;

  localparam logic [23:0] STALL_LIM = STALL_LIMIT[23:0];

  logic        tick_int;
  logic        adv;
  logic [2:0]  pat_state;
  logic [7:0]  leds_reg;
  logic [7:0]  leds_next;
  dir_t        dir_reg;
  dir_t        dir_next;
  logic [15:0] step_count_reg;
  logic [23:0] stall_cnt_reg;
  logic [23:0] stall_cnt_next;
  logic        stall_reg;

  pll_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk_10MHz (clk_10MHz),
    .rst       (rst),
    .clk_pll   (clk_pll),
    .tick      (tick_int)
  );

  // Only ticks that are enabled and not in hold move the pattern and counter
  assign adv = tick_int & enable & (mode != MODE_HOLD);

  // Select the pattern state from the mode and current bounce direction
  always_comb begin
    pat_state = ST_HOLD;
    case (mode)
      MODE_ROTATE: pat_state = ST_ROTATE;
      MODE_BOUNCE: pat_state = (dir_reg == DIR_UP) ? ST_BOUNCE_UP : ST_BOUNCE_DN;
      MODE_COUNT:  pat_state = ST_COUNT;
      default:     pat_state = ST_HOLD;
    endcase
  end

  // Next pattern and direction; shift modes recover from a non-one-hot value
  // by restarting at LED_RESET travelling up
  always_comb begin
    leds_next = leds_reg;
    dir_next  = dir_reg;
    case (pat_state)
      ST_ROTATE: begin
        if (!is_one_hot(leds_reg)) begin
          leds_next = LED_RESET;
          dir_next  = DIR_UP;
        end else begin
          leds_next = {leds_reg[6:0], leds_reg[7]};
        end
      end
      ST_BOUNCE_UP: begin
        if (!is_one_hot(leds_reg)) begin
          leds_next = LED_RESET;
          dir_next  = DIR_UP;
        end else if (leds_reg == 8'h80) begin
          leds_next = 8'h40;
          dir_next  = DIR_DN;
        end else begin
          leds_next = leds_reg << 1;
        end
      end
      ST_BOUNCE_DN: begin
        if (!is_one_hot(leds_reg)) begin
          leds_next = LED_RESET;
          dir_next  = DIR_UP;
        end else if (leds_reg == 8'h01) begin
          leds_next = 8'h02;
          dir_next  = DIR_UP;
        end else begin
          leds_next = leds_reg >> 1;
        end
      end
      ST_COUNT: begin
        leds_next = leds_reg + 8'h01;
      end
      default: begin
        leds_next = leds_reg;
      end
    endcase
  end

  // Commit pattern, direction and step count at the edge ending a tick cycle
  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) begin
      leds_reg       <= LED_RESET;
      dir_reg        <= DIR_UP;
      step_count_reg <= 16'h0000;
    end else if (adv) begin
      leds_reg       <= leds_next;
      dir_reg        <= dir_next;
      step_count_reg <= step_count_reg + 16'h0001;
    end
  end

  // Cycles since the last tick, clearing on a tick and saturating at the limit
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (tick_int) begin
      stall_cnt_next = 24'h000000;
    end else if (stall_cnt_reg != STALL_LIM) begin
      stall_cnt_next = stall_cnt_reg + 24'h000001;
    end
  end

  // Stall monitor: the flag follows the counter landing on the limit, and a
  // tick always wins so a coincident edge never raises it
  always_ff @(posedge clk_10MHz or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= 24'h000000;
      stall_reg     <= 1'b0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
      stall_reg     <= ~tick_int & (stall_cnt_next == STALL_LIM);
    end
  end

  assign tick       = tick_int;
  assign leds       = leds_reg;
  assign step_count = step_count_reg;
  assign stall      = stall_reg;

endmodule
